// File: rtl/conv_ctrl.sv
`default_nettype none
// ============================================================================
// conv_ctrl : row-stream sequencer for a 3x3 convolution datapath + result FIFO
// Optional feature macro: CONV_CTRL_KERNEL_REUSE_EN (adds i_reuse_kernel)
// Revision  : 1.0  initial release
// ============================================================================
module conv_ctrl #(
  parameter int BIT_LEN    = 8,
  parameter int M_LEN      = 3,
  parameter int CONV_LEN   = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [7:0]           i_num_rows,
`ifdef CONV_CTRL_KERNEL_REUSE_EN
  input  logic                 i_reuse_kernel,
`endif
  input  logic                 i_row_valid,
  output logic                 o_row_ready,
  input  logic [3*BIT_LEN-1:0] i_row_data,
  output logic                 o_conv_reset,
  output logic                 o_conv_valid,
  output logic                 o_conv_sel,
  output logic [BIT_LEN-1:0]   o_conv_d0,
  output logic [BIT_LEN-1:0]   o_conv_d1,
  output logic [BIT_LEN-1:0]   o_conv_d2,
  input  logic [CONV_LEN-1:0]  i_conv_data,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [CONV_LEN-1:0]  o_res_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int         c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         c_CNT_W    = c_PTR_W + 1;
  localparam logic [7:0] c_MIN_ROWS = 8'(M_LEN);
  localparam logic [7:0] c_LAST_K   = 8'(M_LEN - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_K = 2'd1;
  localparam logic [1:0] S_LOAD_I = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [7:0]          r_num_rows;
  logic [7:0]          r_row_cnt;
  logic                r_launch_d1;
  logic                r_launch_d2;
  logic                r_conv_reset;
  logic [CONV_LEN-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_reuse;
  logic                w_legal_start;
  logic [1:0]          w_inflight;
  logic [c_CNT_W:0]    w_pending;
  logic                w_fifo_empty;
  logic                w_drained;
  logic                w_row_ready;
  logic                w_accept;
  logic                w_k_last;
  logic                w_i_last;
  logic                w_launch;
  logic                w_push;
  logic                w_pop;

`ifdef CONV_CTRL_KERNEL_REUSE_EN
  assign w_reuse = i_reuse_kernel;
`else
  assign w_reuse = 1'b0;
`endif

  assign w_legal_start = i_start && (i_num_rows >= c_MIN_ROWS);
  assign w_inflight    = {1'b0, r_launch_d1} + {1'b0, r_launch_d2};
  // Beats in flight reserve their FIFO slot at acceptance, so the FIFO cannot overflow.
  assign w_pending     = {1'b0, r_count} + (c_CNT_W + 1)'(w_inflight);
  assign w_fifo_empty  = (r_count == '0);
  assign w_drained     = (w_inflight == 2'd0) && w_fifo_empty;
  assign w_accept      = i_row_valid && w_row_ready;
  assign w_k_last      = (r_row_cnt == c_LAST_K);
  assign w_i_last      = (r_row_cnt == (r_num_rows - 8'd1));
  assign w_launch      = w_accept && (r_state == S_LOAD_I) && (r_row_cnt >= c_LAST_K);
  assign w_push        = r_launch_d2;
  assign w_pop         = o_res_valid && i_res_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_legal_start) w_state_nxt = w_reuse ? S_LOAD_I : S_LOAD_K;
      S_LOAD_K: if (w_accept && w_k_last) w_state_nxt = S_LOAD_I;
      S_LOAD_I: if (w_accept && w_i_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_drained) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_row_ready = 1'b0;
    o_conv_sel  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_err = i_reset && i_start && (i_num_rows < c_MIN_ROWS);
      end
      S_LOAD_K: begin
        w_row_ready = 1'b1;
        o_busy      = 1'b1;
      end
      S_LOAD_I: begin
        w_row_ready = (w_pending < (c_CNT_W + 1)'(FIFO_DEPTH));
        o_conv_sel  = 1'b1;
        o_busy      = 1'b1;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        o_done = w_drained;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  assign o_row_ready  = w_row_ready;
  assign o_conv_valid = w_accept;
  assign o_conv_d0    = i_row_data[BIT_LEN-1:0];
  assign o_conv_d1    = i_row_data[2*BIT_LEN-1:BIT_LEN];
  assign o_conv_d2    = i_row_data[3*BIT_LEN-1:2*BIT_LEN];
  assign o_conv_reset = r_conv_reset | ~i_reset;

  // Row counter indexes kernel rows in LOAD_K and image rows in LOAD_I.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_num_rows   <= '0;
      r_row_cnt    <= '0;
      r_launch_d1  <= 1'b0;
      r_launch_d2  <= 1'b0;
      r_conv_reset <= 1'b1;
    end else begin
      r_conv_reset <= 1'b0;
      r_launch_d1  <= w_launch;
      r_launch_d2  <= r_launch_d1;
      if ((r_state == S_IDLE) && w_legal_start) begin
        r_num_rows <= i_num_rows;
        r_row_cnt  <= '0;
      end else if (w_accept) begin
        if ((r_state == S_LOAD_K) && w_k_last) begin
          r_row_cnt <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_conv_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_res_valid = !w_fifo_empty;
  assign o_res_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire
